// File: rtl/edge_det_pkg.sv
// Shared types and constants for the edge-detection line-buffer sequencer.
package edge_det_pkg;

  typedef enum logic [1:0] {
    S_WAIT_FRAME = 2'd0,
    S_HBLANK     = 2'd1,
    S_ACTIVE     = 2'd2
  } lb_state_e;

  typedef logic [1:0] bank_t;

  localparam bank_t WR_BANK_RST  = 2'd0;
  localparam bank_t MID_BANK_RST = 2'd2;
  localparam bank_t TOP_BANK_RST = 2'd1;

  localparam int unsigned MAX_WIDTH_DEFAULT = 640;

  // Modulo-3 increment over the three physical line banks.
  function automatic bank_t next_bank(input bank_t b);
    return (b == 2'd2) ? 2'd0 : bank_t'(b + 2'd1);
  endfunction

endpackage

// File: rtl/lb_bank_rotator.sv
// Holds the write/middle/top bank indices; rotates at end-of-line, restarts per frame.
module lb_bank_rotator
  import edge_det_pkg::*;
(
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       rotate_i,
  input  logic       restart_i,
  output logic [1:0] wr_bank_o,
  output logic [1:0] mid_bank_o,
  output logic [1:0] top_bank_o
);

  bank_t wr_q, wr_d;
  bank_t mid_q, mid_d;
  bank_t top_q, top_d;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_q  <= WR_BANK_RST;
      mid_q <= MID_BANK_RST;
      top_q <= TOP_BANK_RST;
    end else begin
      wr_q  <= wr_d;
      mid_q <= mid_d;
      top_q <= top_d;
    end
  end

  // Restart wins over rotate so a frame start always lands on the reset ordering.
  always_comb begin
    wr_d  = wr_q;
    mid_d = mid_q;
    top_d = top_q;
    if (restart_i) begin
      wr_d  = WR_BANK_RST;
      mid_d = MID_BANK_RST;
      top_d = TOP_BANK_RST;
    end else if (rotate_i) begin
      wr_d  = next_bank(wr_q);
      mid_d = wr_q;
      top_d = mid_q;
    end
  end

  assign wr_bank_o  = wr_q;
  assign mid_bank_o = mid_q;
  assign top_bank_o = top_q;

endmodule

// File: rtl/line_buffer_ctrl.sv
// Line-buffer sequencer for the 3x3 Sobel window: tracks frame/line/pixel position
// from strobed video timing and drives RAM enables, addresses and bank selects.
module line_buffer_ctrl
  import edge_det_pkg::*;
#(
  parameter int unsigned MAX_WIDTH = MAX_WIDTH_DEFAULT,
  parameter int unsigned COL_W     = 10,
  parameter int unsigned ROW_W     = 9
) (
  input  logic             I_CORE_CLK,
  input  logic             I_RST,
  input  logic             I_PIX_VALID,
  input  logic             I_VSYNC,
  input  logic             I_HSYNC,
  input  logic             I_DE,
  output logic             O_WR_EN,
  output logic [1:0]       O_WR_BANK,
  output logic [COL_W-1:0] O_WR_ADDR,
  output logic             O_RD_EN,
  output logic [COL_W-1:0] O_RD_ADDR,
  output logic [1:0]       O_MID_BANK,
  output logic [1:0]       O_TOP_BANK,
  output logic             O_WIN_VALID,
  output logic             O_LINE_DONE,
  output logic             O_FRAME_START,
  output logic [ROW_W-1:0] O_ROW,
  output logic             O_ERR_OVF
);

  lb_state_e        state_q, state_d;
  logic [COL_W-1:0] col_q, col_d;
  logic [ROW_W-1:0] row_q, row_d;
  logic [COL_W-1:0] wr_addr_q, wr_addr_d;
  logic             prev_vsync_q, prev_vsync_d;
  logic             wr_en_q, wr_en_d;
  logic             win_valid_q, win_valid_d;
  logic             line_done_q, line_done_d;
  logic             frame_start_q, frame_start_d;
  logic             ovf_q, ovf_d;
  logic             rotate_c, restart_c, vsync_rise_c;
  logic             hsync_unused;

  // HSYNC carries no information here: DE alone delimits the line.
  assign hsync_unused = I_HSYNC;

  assign vsync_rise_c = I_PIX_VALID & I_VSYNC & ~prev_vsync_q;

  always_ff @(posedge I_CORE_CLK) begin
    if (I_RST) begin
      state_q       <= S_WAIT_FRAME;
      col_q         <= '0;
      row_q         <= '0;
      wr_addr_q     <= '0;
      prev_vsync_q  <= 1'b0;
      wr_en_q       <= 1'b0;
      win_valid_q   <= 1'b0;
      line_done_q   <= 1'b0;
      frame_start_q <= 1'b0;
      ovf_q         <= 1'b0;
    end else begin
      state_q       <= state_d;
      col_q         <= col_d;
      row_q         <= row_d;
      wr_addr_q     <= wr_addr_d;
      prev_vsync_q  <= prev_vsync_d;
      wr_en_q       <= wr_en_d;
      win_valid_q   <= win_valid_d;
      line_done_q   <= line_done_d;
      frame_start_q <= frame_start_d;
      ovf_q         <= ovf_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    col_d         = col_q;
    row_d         = row_q;
    wr_addr_d     = wr_addr_q;
    prev_vsync_d  = prev_vsync_q;
    wr_en_d       = 1'b0;
    win_valid_d   = 1'b0;
    line_done_d   = 1'b0;
    frame_start_d = 1'b0;
    ovf_d         = ovf_q;
    rotate_c      = 1'b0;
    restart_c     = 1'b0;

    if (I_PIX_VALID) begin
      prev_vsync_d = I_VSYNC;
      if (vsync_rise_c) begin
        // Frame start aborts any partial line and drops a coincident pixel.
        state_d       = S_HBLANK;
        col_d         = '0;
        row_d         = '0;
        frame_start_d = 1'b1;
        restart_c     = 1'b1;
      end else if (state_q != S_WAIT_FRAME) begin
        if (I_DE) begin
          state_d = S_ACTIVE;
          if (col_q < COL_W'(MAX_WIDTH)) begin
            wr_en_d     = 1'b1;
            wr_addr_d   = col_q;
            win_valid_d = (row_q >= ROW_W'(2)) && (col_q >= COL_W'(2));
            col_d       = COL_W'(col_q + COL_W'(1));
          end else begin
            ovf_d = 1'b1;
          end
        end else if (state_q == S_ACTIVE) begin
          state_d     = S_HBLANK;
          line_done_d = 1'b1;
          col_d       = '0;
          rotate_c    = 1'b1;
          if (row_q != {ROW_W{1'b1}}) begin
            row_d = ROW_W'(row_q + ROW_W'(1));
          end
        end
      end
    end
  end

  lb_bank_rotator u_bank_rotator (
    .clk_i      (I_CORE_CLK),
    .rst_i      (I_RST),
    .rotate_i   (rotate_c),
    .restart_i  (restart_c),
    .wr_bank_o  (O_WR_BANK),
    .mid_bank_o (O_MID_BANK),
    .top_bank_o (O_TOP_BANK)
  );

  assign O_WR_EN       = wr_en_q;
  assign O_RD_EN       = wr_en_q;
  assign O_WR_ADDR     = wr_addr_q;
  assign O_RD_ADDR     = wr_addr_q;
  assign O_WIN_VALID   = win_valid_q;
  assign O_LINE_DONE   = line_done_q;
  assign O_FRAME_START = frame_start_q;
  assign O_ROW         = row_q;
  assign O_ERR_OVF     = ovf_q;

endmodule

// File: tb/tb_line_buffer_ctrl.sv
// Self-checking bench for line_buffer_ctrl: directed scenarios plus random timing
// compared cycle-by-cycle against a line-count based reference model.
module tb_line_buffer_ctrl;

  localparam int unsigned MAXW = 8;
  localparam int unsigned CW   = 4;
  localparam int unsigned RW   = 3;
  localparam int ROW_MAX = (1 << RW) - 1;

  logic          clk = 1'b0;
  logic          rst = 1'b0, pv = 1'b0, vs = 1'b0, hs = 1'b0, de = 1'b0;
  logic          wr_en, rd_en, win, ld, fs, ovf;
  logic [1:0]    wr_bank, mid_bank, top_bank;
  logic [CW-1:0] wr_addr, rd_addr;
  logic [RW-1:0] row;

  int errors = 0;
  int checks = 0;

  // Reference model: position is tracked as a count of lines since frame start.
  bit m_frame, m_active, m_prev_vs, m_ovf;
  int m_col, m_line;
  bit e_wr, e_win, e_ld, e_fs;
  int e_addr;

  int cnt_wr, cnt_win, cnt_ld, cnt_fs;

  always #5 clk = ~clk;

  line_buffer_ctrl #(.MAX_WIDTH(MAXW), .COL_W(CW), .ROW_W(RW)) dut (
    .I_CORE_CLK   (clk),
    .I_RST        (rst),
    .I_PIX_VALID  (pv),
    .I_VSYNC      (vs),
    .I_HSYNC      (hs),
    .I_DE         (de),
    .O_WR_EN      (wr_en),
    .O_WR_BANK    (wr_bank),
    .O_WR_ADDR    (wr_addr),
    .O_RD_EN      (rd_en),
    .O_RD_ADDR    (rd_addr),
    .O_MID_BANK   (mid_bank),
    .O_TOP_BANK   (top_bank),
    .O_WIN_VALID  (win),
    .O_LINE_DONE  (ld),
    .O_FRAME_START(fs),
    .O_ROW        (row),
    .O_ERR_OVF    (ovf)
  );

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int m_row();
    return (m_line > ROW_MAX) ? ROW_MAX : m_line;
  endfunction

  task automatic model_step();
    e_wr = 0; e_win = 0; e_ld = 0; e_fs = 0;
    if (rst) begin
      m_frame = 0; m_active = 0; m_col = 0; m_line = 0; m_prev_vs = 0; m_ovf = 0;
    end else if (pv) begin
      if (vs && !m_prev_vs) begin
        e_fs = 1; m_frame = 1; m_active = 0; m_col = 0; m_line = 0;
      end else if (m_frame) begin
        if (de) begin
          m_active = 1;
          if (m_col < int'(MAXW)) begin
            e_wr = 1; e_addr = m_col;
            e_win = (m_row() >= 2) && (m_col >= 2);
            m_col++;
          end else begin
            m_ovf = 1;
          end
        end else if (m_active) begin
          e_ld = 1; m_active = 0; m_col = 0; m_line++;
        end
      end
      m_prev_vs = vs;
    end
  endtask

  // Drive one cycle, advance model, sample after the edge and compare everything.
  task automatic step(input bit r, input bit p, input bit v, input bit d);
    rst = r; pv = p; vs = v; de = d; hs = ~d;
    model_step();
    @(posedge clk); #1;
    chk("wr_en", int'(wr_en), int'(e_wr));
    chk("rd_en", int'(rd_en), int'(e_wr));
    if (e_wr) begin
      chk("wr_addr", int'(wr_addr), e_addr);
      chk("rd_addr", int'(rd_addr), e_addr);
      chk("win_valid", int'(win), int'(e_win));
    end else begin
      chk("win_valid_idle", int'(win), 0);
    end
    chk("line_done", int'(ld), int'(e_ld));
    chk("frame_start", int'(fs), int'(e_fs));
    chk("row", int'(row), m_row());
    chk("wr_bank", int'(wr_bank), m_line % 3);
    chk("mid_bank", int'(mid_bank), (m_line + 2) % 3);
    chk("top_bank", int'(top_bank), (m_line + 1) % 3);
    chk("err_ovf", int'(ovf), int'(m_ovf));
    cnt_wr += int'(wr_en); cnt_win += int'(win);
    cnt_ld += int'(ld); cnt_fs += int'(fs);
    @(negedge clk);
  endtask

  task automatic vsync_pulse();
    step(0, 1, 1, 0);
    step(0, 0, 1, 0);
    step(0, 1, 0, 0);
  endtask

  // One line of n pixels, strobe every 4 clocks, followed by a DE-low strobe.
  task automatic send_line(input int n);
    for (int i = 0; i < n; i++) begin
      step(0, 1, 0, 1);
      for (int k = 0; k < 3; k++) step(0, 0, 0, 1);
    end
    step(0, 1, 0, 0);
    step(0, 0, 0, 0);
    step(0, 1, 0, 0);
  endtask

  initial begin
    int w0, ld0;
    bit rvs, rde;
    @(negedge clk);
    step(1, 0, 0, 0);
    step(1, 1, 1, 1);
    chk("lit_rst_wr_bank", int'(wr_bank), 0);
    chk("lit_rst_mid_bank", int'(mid_bank), 2);
    chk("lit_rst_top_bank", int'(top_bank), 1);
    chk("lit_rst_row", int'(row), 0);
    chk("lit_rst_ovf", int'(ovf), 0);

    // First line of a frame
    cnt_wr = 0; cnt_win = 0; cnt_ld = 0; cnt_fs = 0;
    vsync_pulse();
    chk("lit_fs_count", cnt_fs, 1);
    send_line(4);
    chk("lit_l1_writes", cnt_wr, 4);
    chk("lit_l1_ld", cnt_ld, 1);
    chk("lit_l1_win", cnt_win, 0);
    chk("lit_l1_row", int'(row), 1);
    chk("lit_l1_wr_bank", int'(wr_bank), 1);
    chk("lit_l1_mid_bank", int'(mid_bank), 0);
    chk("lit_l1_top_bank", int'(top_bank), 2);
    send_line(4);
    send_line(4);
    chk("lit_l3_win", cnt_win, 2);
    chk("lit_l3_writes", cnt_wr, 12);
    chk("lit_l3_wr_bank", int'(wr_bank), 0);
    chk("lit_l3_mid_bank", int'(mid_bank), 2);
    chk("lit_l3_top_bank", int'(top_bank), 1);

    // VSYNC coincident with the 3rd pixel of a line
    send_line(4);
    w0 = cnt_wr; ld0 = cnt_ld;
    step(0, 1, 0, 1); step(0, 0, 0, 1);
    step(0, 1, 0, 1); step(0, 0, 0, 1);
    step(0, 1, 1, 1);
    chk("lit_vs_mid_fs", int'(fs), 1);
    chk("lit_vs_mid_wr", int'(wr_en), 0);
    chk("lit_vs_mid_row", int'(row), 0);
    chk("lit_vs_mid_bank", int'(wr_bank), 0);
    step(0, 1, 0, 0);
    chk("lit_vs_mid_writes", cnt_wr - w0, 2);
    chk("lit_vs_mid_ld", cnt_ld - ld0, 0);

    // Overflow: 10-pixel line into an 8-deep buffer
    w0 = cnt_wr;
    send_line(10);
    chk("lit_ovf_writes", cnt_wr - w0, 8);
    chk("lit_ovf_set", int'(ovf), 1);
    vsync_pulse();
    chk("lit_ovf_sticky", int'(ovf), 1);

    // Reset mid-line, then lines without VSYNC are ignored
    step(0, 1, 0, 1); step(0, 1, 0, 1);
    step(1, 0, 0, 1);
    chk("lit_rst_mid_wr", int'(wr_en), 0);
    chk("lit_rst_mid_ovf", int'(ovf), 0);
    w0 = cnt_wr;
    send_line(4);
    chk("lit_ignored_writes", cnt_wr - w0, 0);

    // Randomised timing, occasional reset
    rvs = 0; rde = 0;
    for (int c = 0; c < 6000; c++) begin
      if ($urandom_range(0, 149) == 0) rvs = ~rvs;
      if ($urandom_range(0, 9) == 0) rde = ~rde;
      step(($urandom_range(0, 1499) == 0), ($urandom_range(0, 2) == 0), rvs, rde);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
